jk_count_monitor: RTL and testbench
===================================

Name: jk_count_monitor

Overview:
- Downstream consumer of the 3-bit JK ripple/sync counter output Q.
- Samples the count each enabled cycle and checks that it follows the modulo-2^WIDTH up sequence.
- Acquires lock, then reports sequence errors, wrap-arounds and saturating error/wrap statistics to the system/bench.
- All outputs registered; it observes the counter only and never drives it.

Parameters:
- WIDTH, 3, width of the monitored count.
- LOCK_CNT, 2, consecutive correct transitions needed to enter LOCKED (range 1..15).
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 8, width of the wrap counter (wraps modulo 2^WRAP_W).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; when low, q_in is ignored and all state holds.
- q_in  input  WIDTH  count value from the JK counter (Q).
- locked  output  1  high while in LOCKED.
- seq_err  output  1  one-cycle pulse on a bad transition while LOCKED.
- wrap_pulse  output  1  one-cycle pulse on a max->0 transition while LOCKED.
- err_cnt  output  ERR_W  saturating count of seq_err pulses.
- wrap_cnt  output  WRAP_W  count of wrap_pulse events, modulo 2^WRAP_W.
- state  output  2  current FSM state encoding (IDLE=0, ACQ=1, LOCKED=2).

Behaviour:
- Reset values: state=IDLE, locked=0, seq_err=0, wrap_pulse=0, err_cnt=0, wrap_cnt=0, q_prev=0, good_cnt=0.
- Reset applies at the next rising edge and overrides en and q_in. Reset mid-operation clears everything, including err_cnt.
- Sampling: on an edge with en=1, compute expected = (q_prev + 1) mod 2^WIDTH in WIDTH-bit arithmetic.
  - good = (q_in == expected).
  - Then q_prev <= q_in.
- FSM transitions:
  - IDLE: first enabled sample loads q_prev and moves to ACQ with good_cnt=0. No judgement is made on this sample.
  - ACQ, good: good_cnt++. When good_cnt+1 == LOCK_CNT, go to LOCKED and clear good_cnt.
  - ACQ, bad: good_cnt=0, stay in ACQ. No seq_err (errors are only reported while locked).
  - LOCKED, good: stay in LOCKED.
  - LOCKED, bad: seq_err=1 for one cycle, err_cnt++ (saturates at all-ones), go to ACQ with good_cnt=0.
- Wrap detection: in LOCKED, a good transition with q_prev == 2^WIDTH-1 and q_in == 0 pulses wrap_pulse for one cycle and increments wrap_cnt, which rolls over.
- Pulses:
  - seq_err and wrap_pulse are 0 on every cycle not producing an event, including en=0 cycles.
  - The two pulses are mutually exclusive.
- Latency: outputs reflect a sample one cycle after the edge that captured it (registered).
- locked equals (state == LOCKED) and is registered together with state.
- en=0: no sampling, q_prev holds, state and counters hold, no pulses.
- Stall (q_in == q_prev) is a bad transition unless the optional feature is enabled.

Optional Feature:
- Macro: JK_MON_STALL_OK_EN.
- Defined: q_in == q_prev counts as neutral. No error, good_cnt unchanged, state unchanged, no pulses. This supports gated or slowed counters.
- Undefined: a stall is a bad transition, as described above.

Decomposition:
- Package jk_mon_pkg:
  - state encoding constants ST_IDLE, ST_ACQ, ST_LOCKED (2-bit localparams / typedef).
  - default WIDTH, LOCK_CNT, ERR_W, WRAP_W.
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output cnt; saturates at all-ones) implements err_cnt.
- wrap_cnt is a plain counter inside the top module.

Test Plan:
- Reset then free-running counter: reset=1 for 1 cycle, en=1, q_in=0,1,2,... -> IDLE→ACQ on sample 0, locked=1 one cycle after sample 2 (LOCK_CNT=2), seq_err never high.
- Wrap: locked, q_in 6,7,0 -> wrap_pulse=1 exactly one cycle after the 0 sample, wrap_cnt 0→1. After 8 full cycles (64 samples past lock) wrap_cnt=8.
- Glitch: locked at q_prev=3, q_in=5 -> seq_err pulse, err_cnt=1, state=ACQ. Then 6,7 -> locked=1 again.
- Saturation: ERR_W=2, force 5 errors with relock between each -> err_cnt sticks at 3, and seq_err still pulses on every error.
- Enable and stall: en=0 for 4 cycles with q_in changing randomly -> no state or counter change.
  - Then q_in repeats the previous value: without JK_MON_STALL_OK_EN, seq_err=1; with it, locked stays 1 and err_cnt is unchanged.
- Reset mid-operation: locked, err_cnt=2, wrap_cnt=5, reset=1 for 1 cycle -> all outputs 0 and state=IDLE on the following cycle.

Source files
------------

// File: rtl/jk_mon_pkg.sv
// Shared types and defaults for the JK counter sequence monitor.
package jk_mon_pkg;

  // Monitor FSM state; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } jk_mon_state_e;

  localparam int unsigned DEF_WIDTH    = 3;
  localparam int unsigned DEF_LOCK_CNT = 2;
  localparam int unsigned DEF_ERR_W    = 8;
  localparam int unsigned DEF_WRAP_W   = 8;

  // Wide enough for LOCK_CNT up to 15.
  localparam int unsigned GOOD_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count increments, holding once the maximum is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/jk_count_monitor.sv
// Passive monitor for a modulo-2^WIDTH up counter: acquires lock after
// LOCK_CNT consecutive correct steps, then flags bad steps and wrap-arounds.
// Build option JK_MON_STALL_OK_EN: a repeated value is neutral rather than
// a bad transition.
module jk_count_monitor
  import jk_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W,
  parameter int unsigned WRAP_W   = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WIDTH-1:0]  q_in,
  output logic              locked,
  output logic              seq_err,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [1:0]        state
);

`ifdef JK_MON_STALL_OK_EN
  localparam bit StallNeutral = 1'b1;
`else
  localparam bit StallNeutral = 1'b0;
`endif

  localparam logic [GOOD_W-1:0] LockTarget = GOOD_W'(LOCK_CNT);

  jk_mon_state_e       r_state, w_state_d;
  logic [WIDTH-1:0]    r_q_prev, w_q_prev_d;
  logic [GOOD_W-1:0]   r_good_cnt, w_good_cnt_d;
  logic                r_locked;
  logic                r_seq_err;
  logic                r_wrap_pulse;
  logic [WRAP_W-1:0]   r_wrap_cnt;

  logic [WIDTH-1:0]    w_expected;
  logic                w_good;
  logic                w_neutral;
  logic                w_err_ev;
  logic                w_wrap_ev;

  assign w_expected = r_q_prev + 1'b1;
  assign w_good     = (q_in == w_expected);
  assign w_neutral  = StallNeutral && (q_in == r_q_prev);

  // Next-state, acquisition counter and event decode for one enabled sample.
  always_comb begin
    w_state_d    = r_state;
    w_q_prev_d   = r_q_prev;
    w_good_cnt_d = r_good_cnt;
    w_err_ev     = 1'b0;
    w_wrap_ev    = 1'b0;
    if (en) begin
      w_q_prev_d = q_in;
      unique case (r_state)
        ST_IDLE: begin
          // First sample only seeds q_prev.
          w_state_d    = ST_ACQ;
          w_good_cnt_d = '0;
        end
        ST_ACQ: begin
          if (w_neutral) begin
            w_state_d = r_state;
          end else if (w_good) begin
            if (r_good_cnt + 1'b1 == LockTarget) begin
              w_state_d    = ST_LOCKED;
              w_good_cnt_d = '0;
            end else begin
              w_good_cnt_d = r_good_cnt + 1'b1;
            end
          end else begin
            w_good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (w_neutral) begin
            w_state_d = r_state;
          end else if (w_good) begin
            w_wrap_ev = (r_q_prev == '1) && (q_in == '0);
          end else begin
            w_err_ev     = 1'b1;
            w_state_d    = ST_ACQ;
            w_good_cnt_d = '0;
          end
        end
        default: begin
          w_state_d    = ST_IDLE;
          w_good_cnt_d = '0;
        end
      endcase
    end
  end

  // State, sample history, registered pulses and wrap count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_q_prev     <= '0;
      r_good_cnt   <= '0;
      r_locked     <= 1'b0;
      r_seq_err    <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_cnt   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_q_prev     <= w_q_prev_d;
      r_good_cnt   <= w_good_cnt_d;
      r_locked     <= (w_state_d == ST_LOCKED);
      r_seq_err    <= w_err_ev;
      r_wrap_pulse <= w_wrap_ev;
      if (w_wrap_ev) begin
        r_wrap_cnt <= r_wrap_cnt + 1'b1;
      end
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err_ev),
    .cnt   (err_cnt)
  );

  assign locked     = r_locked;
  assign seq_err    = r_seq_err;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_cnt   = r_wrap_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_jk_count_monitor.sv
// Scoreboard bench for jk_count_monitor: a driver issues samples and queues
// the behaviour-level expectation; a monitor pops one entry per cycle.
module tb_jk_count_monitor;

  localparam int unsigned WIDTH    = 3;
  localparam int unsigned LOCK_CNT = 2;
  localparam int unsigned ERR_W    = 2;
  localparam int unsigned WRAP_W   = 8;
  localparam int          MODV     = 1 << WIDTH;
  localparam int          ERR_MAX  = (1 << ERR_W) - 1;
  localparam int          WRAP_MOD = 1 << WRAP_W;

`ifdef JK_MON_STALL_OK_EN
  localparam bit STALL_OK = 1'b1;
`else
  localparam bit STALL_OK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [WIDTH-1:0]  q_in;
  logic              locked;
  logic              seq_err;
  logic              wrap_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [1:0]        state;

  jk_count_monitor #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT),
    .ERR_W    (ERR_W),
    .WRAP_W   (WRAP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .q_in       (q_in),
    .locked     (locked),
    .seq_err    (seq_err),
    .wrap_pulse (wrap_pulse),
    .err_cnt    (err_cnt),
    .wrap_cnt   (wrap_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int lk;
    int se;
    int wp;
    int ec;
    int wc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 = not started, 1 = acquiring, 2 = locked.
  int m_mode = 0;
  int m_prev = 0;
  int m_run  = 0;
  int m_errs = 0;
  int m_wraps = 0;
  int cur = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Apply one cycle of stimulus and queue what the outputs must show after it.
  task automatic step(input bit r, input bit e, input int q);
    exp_t x;
    bit   good;
    bit   stall;
    reset = r;
    en    = e;
    q_in  = q[WIDTH-1:0];
    x.se  = 0;
    x.wp  = 0;
    if (r) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0;
    end else if (e) begin
      good  = (q == (m_prev + 1) % MODV);
      stall = (q == m_prev);
      if (m_mode == 0) begin
        m_mode = 1;
        m_run  = 0;
      end else if (stall && STALL_OK) begin
        // neutral sample
      end else if (m_mode == 1) begin
        if (good) begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_mode = 2;
            m_run  = 0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (good) begin
          if (m_prev == MODV - 1 && q == 0) begin
            x.wp    = 1;
            m_wraps = (m_wraps + 1) % WRAP_MOD;
          end
        end else begin
          x.se   = 1;
          m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : m_errs;
          m_mode = 1;
          m_run  = 0;
        end
      end
      m_prev = q;
    end
    x.st = m_mode;
    x.lk = (m_mode == 2) ? 1 : 0;
    x.ec = m_errs;
    x.wc = m_wraps;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic count(input int n);
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % MODV;
      step(1'b0, 1'b1, cur);
    end
  endtask

  // Monitor: outputs are compared on the falling edge after each sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",      int'(state),      e.st);
        check("locked",     int'(locked),     e.lk);
        check("seq_err",    int'(seq_err),    e.se);
        check("wrap_pulse", int'(wrap_pulse), e.wp);
        check("err_cnt",    int'(err_cnt),    e.ec);
        check("wrap_cnt",   int'(wrap_cnt),   e.wc);
      end
    end
  end

  initial begin
    int r;
    // Reset overrides en and q_in.
    step(1'b1, 1'b1, 5);
    // Free-running count from 0, through several wraps.
    cur = 0;
    step(1'b0, 1'b1, cur);
    count(12);
    // Glitch at q_prev = 3, then relock on 6,7.
    while (cur != 3) count(1);
    cur = 5;
    step(1'b0, 1'b1, cur);
    count(2);
    // Five errors with relock between: err_cnt saturates at 3.
    repeat (5) begin
      cur = (cur + 3) % MODV;
      step(1'b0, 1'b1, cur);
      count(3);
    end
    // Enable low with changing q_in: nothing moves.
    repeat (4) step(1'b0, 1'b0, $urandom_range(0, MODV - 1));
    // Stall while locked.
    step(1'b0, 1'b1, cur);
    count(3);
    // Long run: 64 samples gives 8 more wraps.
    count(64);
    // Reset mid-operation.
    step(1'b1, 1'b1, cur);
    count(6);
    // Randomised mix of counting, jumps, stalls, enable gaps and rare resets.
    repeat (600) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, $urandom_range(0, 1), $urandom_range(0, MODV - 1));
      end else if (r < 12) begin
        step(1'b0, 1'b0, $urandom_range(0, MODV - 1));
      end else if (r < 18) begin
        cur = $urandom_range(0, MODV - 1);
        step(1'b0, 1'b1, cur);
      end else if (r < 22) begin
        step(1'b0, 1'b1, cur);
      end else begin
        count(1);
      end
    end
    en    = 1'b0;
    reset = 1'b0;
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
